sysid_reader: RTL and testbench

Avalon-MM master that reads the system-ID peripheral's two words (word 0 = system ID, word 1 = build timestamp) and compares them against expected constants baked in at synthesis. Sits beside the HPS/Nios bridge on the same slave port and gives boot-check logic a hardware "correct bitstream loaded" flag, with no processor involved. Runs once automatically after reset and again on each `start` pulse. Bounds every bus read with a timeout.

---
 rtl/sysid_pkg.sv | 21 ++
 rtl/sysid_reader.sv | 135 +++++++++++++
 tb/tb_sysid_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Holds the FSM state encoding, the word addresses and the compare helper.
package sysid_pkg;

  localparam int DATA_W = 32;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } state_e;

  function automatic logic word_match(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/sysid_reader.sv
// Avalon-MM master that reads the system-ID words and compares them to build-time constants.
// Flags a stuck slave through a bounded wait counter instead of hanging the boot check.
module sysid_reader
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1614243730,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          AUTO_START     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_match,
  output logic              ts_match,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        AUTO_EN   = (AUTO_START != 0);

  state_e            state_r;
  logic              auto_pend_r;
  logic [15:0]       wait_cnt_r;
  logic              avm_address_r;
  logic              avm_read_r;
  logic              busy_r;
  logic              done_r;
  logic              id_match_r;
  logic              ts_match_r;
  logic              timeout_r;
  logic [DATA_W-1:0] id_value_r;
  logic [DATA_W-1:0] ts_value_r;
  logic              accept_s;
  logic              wait_expired_s;

  assign accept_s       = avm_read_r && !avm_waitrequest;
  assign wait_expired_s = avm_waitrequest && (wait_cnt_r == WAIT_LAST);

  // Check sequencer: issues both reads, captures data, compares, aborts on a stalled slave.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      auto_pend_r   <= AUTO_EN;
      wait_cnt_r    <= 16'd0;
      avm_address_r <= ADDR_ID;
      avm_read_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      id_match_r    <= 1'b0;
      ts_match_r    <= 1'b0;
      timeout_r     <= 1'b0;
      id_value_r    <= {DATA_W{1'b0}};
      ts_value_r    <= {DATA_W{1'b0}};
    end else begin
      auto_pend_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start || auto_pend_r) begin
            state_r       <= RD_ID;
            wait_cnt_r    <= 16'd0;
            avm_address_r <= ADDR_ID;
            avm_read_r    <= 1'b1;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            id_match_r    <= 1'b0;
            ts_match_r    <= 1'b0;
            timeout_r     <= 1'b0;
            id_value_r    <= {DATA_W{1'b0}};
            ts_value_r    <= {DATA_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ID, RD_TS: begin
          if (accept_s) begin
            wait_cnt_r <= 16'd0;
            if (state_r == RD_ID) begin
              id_value_r    <= avm_readdata;
              avm_address_r <= ADDR_TS;
              state_r       <= RD_TS;
            end else begin
              ts_value_r    <= avm_readdata;
              avm_address_r <= ADDR_ID;
              avm_read_r    <= 1'b0;
              state_r       <= FIN;
            end
          end else if (wait_expired_s) begin
            // Abort leaves whatever was captured so far visible for diagnosis.
            wait_cnt_r    <= 16'd0;
            avm_read_r    <= 1'b0;
            avm_address_r <= ADDR_ID;
            timeout_r     <= 1'b1;
            done_r        <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        FIN: begin
          id_match_r <= word_match(id_value_r, EXPECTED_ID);
          ts_match_r <= word_match(ts_value_r, EXPECTED_TS);
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          avm_read_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign avm_address = avm_address_r;
  assign avm_read    = avm_read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_match    = id_match_r;
  assign ts_match    = ts_match_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_sysid_reader.sv
// Scoreboard bench for sysid_reader: instance A (auto-start, short timeout) and
// instance B (no auto-start) for the mid-check reset scenario.
module tb_sysid_reader;

  localparam logic [31:0] TS_OK  = 32'd1614243730;
  localparam logic [31:0] TS_BAD = 32'd1614243731;
  localparam logic [31:0] ID_B   = 32'h1234_5678;

  typedef struct {
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          cyc;
    int          ts_rd;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Instance A signals and slave model
  logic        reset_n_a = 1'b0, start_a = 1'b0;
  logic        addr_a, read_a, wr_a, busy_a, done_a, idm_a, tsm_a, to_a;
  logic [31:0] rdata_a, idv_a, tsv_a;
  logic [31:0] data_id_a = 32'd0, data_ts_a = TS_OK;
  int          ws_a = 0;
  logic        stuck_ts_a = 1'b0;
  int          stall_cnt = 0;

  assign wr_a    = read_a && ((stuck_ts_a && addr_a) || (stall_cnt < ws_a));
  assign rdata_a = addr_a ? data_ts_a : data_id_a;
  always @(posedge clock) stall_cnt <= (read_a && wr_a) ? stall_cnt + 1 : 0;

  sysid_reader #(.TIMEOUT_CYCLES(8), .AUTO_START(1)) dut_a (
    .clock(clock), .reset_n(reset_n_a), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .id_match(idm_a), .ts_match(tsm_a), .timeout(to_a),
    .id_value(idv_a), .ts_value(tsv_a)
  );

  // Instance B: zero-wait slave, no auto-start
  logic        reset_n_b = 1'b0, start_b = 1'b0;
  logic        addr_b, read_b, busy_b, done_b, idm_b, tsm_b, to_b;
  logic [31:0] rdata_b, idv_b, tsv_b;
  logic        wr_b = 1'b0;
  logic        b_read_seen = 1'b0;
  assign rdata_b = addr_b ? TS_OK : ID_B;

  sysid_reader #(.AUTO_START(0)) dut_b (
    .clock(clock), .reset_n(reset_n_b), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_match(idm_b), .ts_match(tsm_b), .timeout(to_b),
    .id_value(idv_b), .ts_value(tsv_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: bus protocol checks plus scoreboard pop on each rising done of instance A
  logic done_prev = 1'b0, prev_stall = 1'b0, prev_addr = 1'b0, exp_addr = 1'b0;
  int   ts_rd_cnt = 0;
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (read_b) b_read_seen = 1'b1;
    if (prev_stall && !to_a) begin
      chk("stall_read_held", read_a, 1);
      chk("stall_addr_held", addr_a, prev_addr);
    end
    if (read_a && addr_a) ts_rd_cnt++;
    if (read_a && !wr_a) begin
      chk("accept_addr", addr_a, exp_addr);
      exp_addr = ~exp_addr;
    end
    if (done_a && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("id_match", idm_a, e.idm);
        chk("ts_match", tsm_a, e.tsm);
        chk("timeout", to_a, e.to);
        chk("id_value", idv_a, e.idv);
        chk("ts_value", tsv_a, e.tsv);
        chk("busy_low", busy_a, 0);
        chk("ts_read_cycles", ts_rd_cnt, e.ts_rd);
      end
      ts_rd_cnt = 0;
      exp_addr  = 1'b0;
    end
    done_prev  = done_a;
    prev_stall = read_a && wr_a;
    prev_addr  = addr_a;
  end

  task automatic pulse_a(output int k);
    @(negedge clock);
    k = cyc;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic pulse_b(output int k);
    @(negedge clock);
    k = cyc;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
  endtask

  task automatic push(input logic idm, input logic tsm, input logic to, input logic [31:0] idv,
                      input logic [31:0] tsv, input int c, input int ts_rd);
    exp_t e;
    e.idm = idm; e.tsm = tsm; e.to = to; e.idv = idv; e.tsv = tsv; e.cyc = c; e.ts_rd = ts_rd;
    sb.push_back(e);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clock);
    chk("reset_state_a", {read_a, addr_a, busy_a, done_a, idm_a, tsm_a, to_a, idv_a, tsv_a}, 0);

    // Auto-start after reset release: done 4 cycles later
    @(negedge clock);
    k = cyc;
    reset_n_a = 1'b1;
    push(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, k + 4, 1);
    wait_sb();

    // Wrong timestamp
    data_ts_a = TS_BAD;
    pulse_a(k);
    push(1'b1, 1'b0, 1'b0, 32'd0, TS_BAD, k + 4, 1);
    wait_sb();
    data_ts_a = TS_OK;

    // Three wait states on each read
    ws_a = 3;
    pulse_a(k);
    push(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, k + 10, 4);
    wait_sb();
    ws_a = 0;

    // Stuck slave on timestamp read: 8 read cycles then abort
    stuck_ts_a = 1'b1;
    pulse_a(k);
    push(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, k + 10, 8);
    wait_sb();
    stuck_ts_a = 1'b0;

    // Start while busy is ignored; start after done reruns and clears flags on entry
    pulse_a(k);
    push(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, k + 4, 1);
    chk("entry_clears_done", done_a, 0);
    chk("entry_sets_busy", busy_a, 1);
    pulse_a(k);
    wait_sb();
    repeat (10) @(negedge clock);
    pulse_a(k);
    push(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, k + 4, 1);
    chk("rerun_clears_done", done_a, 0);
    wait_sb();

    // Instance B: reset during RD_TS, then no read until start
    reset_n_b = 1'b1;
    repeat (4) @(negedge clock);
    chk("b_no_autostart", b_read_seen, 0);
    pulse_b(k);
    @(negedge clock);
    chk("b_rd_ts_addr", {read_b, addr_b}, 2'b11);
    chk("b_id_captured", idv_b, ID_B);
    #2 reset_n_b = 1'b0;
    #1 chk("b_async_reset", {read_b, addr_b, busy_b, done_b, idm_b, tsm_b, to_b, idv_b, tsv_b}, 0);
    @(negedge clock);
    reset_n_b   = 1'b1;
    b_read_seen = 1'b0;
    repeat (6) @(negedge clock);
    chk("b_idle_after_reset", {b_read_seen, busy_b}, 0);
    pulse_b(k);
    repeat (2) @(negedge clock);
    chk("b_done_not_early", done_b, 0);
    @(negedge clock);
    chk("b_done", done_b, 1);
    chk("b_id_match", idm_b, 0);
    chk("b_ts_match", tsm_b, 1);
    chk("b_id_value", idv_b, ID_B);
    chk("b_ts_value", tsv_b, TS_OK);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
